// File: rtl/uart_tx_port.sv
// Register-mapped 8N1 serial transmitter: captures core register writes into a
// byte FIFO, shifts bytes out on txd and reports FIFO/FSM state on status.
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic        sysclk,
  input  logic        sysreset_n,
  input  logic [15:0] wr_data,
  input  logic        wr_load,
  output logic [15:0] status,
  output logic        txd
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]      BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full, is_ctrl, is_data, push, pop, tick;
  logic [4:0] cnt_ext;
  logic unused_bits;

  assign unused_bits = ^wr_data[14:8];

  always_comb begin
    pend_d     = wr_load;
    is_ctrl    = pend_q & wr_data[15];
    is_data    = pend_q & ~wr_data[15];
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_FULL);
    tick       = (timer_q == '0);

    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          state_d = S_START;
          timer_d = BIT_LAST;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
          timer_d = BIT_LAST;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          timer_d = BIT_LAST;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          // Chain straight into the next START so frames run back-to-back.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = S_START;
            timer_d = BIT_LAST;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    push = is_data & (~fifo_full | pop);

    ovf_d = ovf_q;
    if (is_data && !push) ovf_d = 1'b1;
    if (is_ctrl)          ovf_d = 1'b0;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem_q[wptr_q] <= wr_data[7:0];
  end

  always_comb begin
    cnt_ext            = '0;
    cnt_ext[FIFO_AW:0] = count_q;
  end

  assign status = {7'd0, cnt_ext, ovf_q, (state_q != S_IDLE), fifo_empty, fifo_full};
  assign txd    = txd_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port at 4 clocks per bit: vector table of single
// writes plus hand sequences for back-to-back frames, overflow and reset.
module tb_uart_tx_port;

  logic        sysclk;
  logic        sysreset_n;
  logic [15:0] wr_data;
  logic        wr_load;
  logic [15:0] status;
  logic        txd;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;

  uart_tx_port #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (16),
    .FIFO_AW     (4)
  ) dut (
    .sysclk    (sysclk),
    .sysreset_n(sysreset_n),
    .wr_data   (wr_data),
    .wr_load   (wr_load),
    .status    (status),
    .txd       (txd)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] wdata;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns one cycle after the capture edge (E1 + 1).
  task automatic wr1(input logic [15:0] v);
    wr_load = 1'b1;
    step();
    wr_data = v;
    wr_load = 1'b0;
    step();
  endtask

  // Call one cycle after the START edge; returns one cycle after the frame ends.
  task automatic rx_frame(output logic [7:0] b);
    b = '0;
    repeat (6) step();
    for (int j = 0; j < 8; j++) begin
      b[j] = txd;
      if (j < 7) repeat (4) step();
    end
    repeat (4) step();
    chk("stop_bit", {15'd0, txd}, 16'd1);
    repeat (2) step();
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] burst [17];
    int unsigned t0;

    vecs[0] = '{16'h0055, 8'h55};
    vecs[1] = '{16'h00A3, 8'hA3};
    vecs[2] = '{16'h7F3C, 8'h3C};
    vecs[3] = '{16'h00FF, 8'hFF};
    vecs[4] = '{16'h0000, 8'h00};

    wr_data    = '0;
    wr_load    = 1'b0;
    sysreset_n = 1'b0;
    repeat (3) step();
    chk("reset_status", status, 16'h0002);
    chk("reset_txd", {15'd0, txd}, 16'd1);
    sysreset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      wr1(vecs[i].wdata);
      chk("status_after_push", status, 16'h0010);
      step();
      chk("txd_start", {15'd0, txd}, 16'd0);
      chk("status_busy", status, 16'h0006);
      rx_frame(b);
      chk("rx_byte", {8'd0, b}, {8'd0, vecs[i].exp_byte});
      chk("status_idle", status, 16'h0002);
      chk("txd_idle", {15'd0, txd}, 16'd1);
      step();
    end

    // Three writes on consecutive cycles, frames must chain with no gap.
    wr_load = 1'b1;
    step();
    wr_data = 16'h0041; step();
    wr_data = 16'h0042; step();
    wr_data = 16'h0043; wr_load = 1'b0; step();
    chk("b2b_start", {15'd0, txd}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      rx_frame(b);
      chk("b2b_byte", {8'd0, b}, 16'h0041 + 16'(i));
      if (i < 2) chk("b2b_no_gap", {15'd0, txd}, 16'd0);
    end
    chk("b2b_end_status", status, 16'h0002);
    chk("b2b_end_txd", {15'd0, txd}, 16'd1);
    step();

    // Overflow: one frame in flight, then 17 queued writes.
    wr1(16'h00A0);
    step();
    t0 = cyc;
    chk("ovf_pre_start", {15'd0, txd}, 16'd0);
    for (int i = 0; i < 17; i++) burst[i] = 16'(i + 1);
    wr_load = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      wr_data = burst[i];
      wr_load = (i < 16);
      step();
      if (i == 15) chk("full_no_ovf", status, 16'h0105);
    end
    chk("overflow_status", status, 16'h010D);
    wr1(16'h8000);
    chk("ovf_cleared", status, 16'h0105);
    while (cyc < t0 + 40) step();
    chk("queue_start", {15'd0, txd}, 16'd0);
    for (int i = 0; i < 16; i++) begin
      rx_frame(b);
      chk("queue_byte", {8'd0, b}, 16'(i + 1));
    end
    chk("queue_drained", status, 16'h0002);
    chk("no_extra_frame", {15'd0, txd}, 16'd1);
    step();

    // Asynchronous reset in the middle of DATA.
    wr1(16'h00F0);
    repeat (12) step();
    chk("pre_reset_busy", status, 16'h0006);
    sysreset_n = 1'b0;
    #2;
    chk("async_rst_txd", {15'd0, txd}, 16'd1);
    chk("async_rst_status", status, 16'h0002);
    step();
    #3 sysreset_n = 1'b1;
    step();
    chk("post_rst_status", status, 16'h0002);
    wr1(16'h0055);
    step();
    chk("post_rst_start", {15'd0, txd}, 16'd0);
    rx_frame(b);
    chk("post_rst_byte", {8'd0, b}, 16'h0055);
    chk("post_rst_idle", status, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
